vga_cell_renderer: RTL and testbench

Parametrised VGA scan-out engine replacing the fixed 640x480 sync generator and ad-hoc cell-to-colour logic in the top level. It generates sync timing and issues framebuffer cell addresses for CELL_SHIFT-sized square cells. It absorbs a configurable memory read latency and maps each 8-bit cell to 4-bit RGB through a per-frame selectable colour mode, with an optional blinking cursor. It sits between the pixel-clock PLL output and the VGA pins, and reads the CPU core's cell memory port.

---
 rtl/vga_cell_renderer_if.sv | 11 +
 rtl/vga_cell_renderer.sv | 155 +++++++++++++++
 tb/tb_vga_cell_renderer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_cell_renderer_if.sv
// Cell memory read port: vga_cell_renderer drives the address (master),
// the framebuffer returns the cell byte (slave).
interface vga_cell_renderer_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] cell_addr;
    logic [7:0]        cell_data;

    modport master (output cell_addr, input  cell_data);
    modport slave  (input  cell_addr, output cell_data);
endinterface

// File: rtl/vga_cell_renderer.sv
// Parametrised VGA scan-out: sync timing, cell address fetch, latency-matched colour mapping.
// Optional blinking cursor highlight is built only when VGA_CURSOR_EN is defined.
module vga_cell_renderer #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CELL_SHIFT  = 3,
    parameter int COL_W       = 7,
    parameter int ROW_W       = 7,
    parameter int MEM_LAT     = 1,
    parameter int BLINK_SHIFT = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode,
    vga_cell_renderer_if.master    mem,
    input  logic [ROW_W+COL_W-1:0] cursor_addr,
    input  logic                   cursor_en,
    output logic                   vga_h_sync,
    output logic                   vga_v_sync,
    output logic [3:0]             r,
    output logic [3:0]             g,
    output logic [3:0]             b,
    output logic                   in_display,
    output logic                   frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL + 1);
    localparam int YW      = $clog2(V_TOTAL + 1);
    localparam int AW      = ROW_W + COL_W;

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_HS0  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_HS1  = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_VS0  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_VS1  = YW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        NIBBLE = 2'd0,
        GRAY   = 2'd1,
        RGB332 = 2'd2,
        MONO   = 2'd3
    } mode_t;

    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    mode_t              frame_mode;
    logic               act_c, hs_c, vs_c, org_c;
    logic [AW-1:0]      addr_c;
    logic [MEM_LAT-1:0] act_d, hs_d, vs_d, org_d;
    logic               blink_on;
    logic [11:0]        pix;

    always_comb begin
        act_c  = (x < X_ACT) && (y < Y_ACT);
        hs_c   = !((x >= X_HS0) && (x < X_HS1));
        vs_c   = !((y >= Y_VS0) && (y < Y_VS1));
        org_c  = (x == '0) && (y == '0);
        addr_c = {ROW_W'(y >> CELL_SHIFT), COL_W'(x >> CELL_SHIFT)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            frame_mode <= NIBBLE;
        end else begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
            if (org_c) frame_mode <= mode_t'(mode);
        end
    end

    // Side bits enter the delay line on the same edge that registers cell_addr,
    // so the last stage lines up with cell_data MEM_LAT-1 cycles later.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem.cell_addr <= '0;
            act_d         <= '0;
            hs_d          <= '1;
            vs_d          <= '1;
            org_d         <= '0;
        end else begin
            mem.cell_addr <= addr_c;
            act_d         <= MEM_LAT'({act_d, act_c});
            hs_d          <= MEM_LAT'({hs_d, hs_c});
            vs_d          <= MEM_LAT'({vs_d, vs_c});
            org_d         <= MEM_LAT'({org_d, org_c});
        end
    end

`ifdef VGA_CURSOR_EN
    logic [BLINK_SHIFT:0] frame_cnt;
    logic [MEM_LAT-1:0]   match_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            match_d   <= '0;
        end else begin
            if (org_c) frame_cnt <= frame_cnt + (BLINK_SHIFT + 1)'(1);
            match_d <= MEM_LAT'({match_d, cursor_en && (addr_c == cursor_addr)});
        end
    end

    assign blink_on = match_d[MEM_LAT-1] && frame_cnt[BLINK_SHIFT];
`else
    logic unused_cursor;
    assign unused_cursor = ^{cursor_en, cursor_addr};
    assign blink_on      = 1'b0;
`endif

    always_comb begin
        pix = '0;
        case (frame_mode)
            NIBBLE: pix = {mem.cell_data[7:4], mem.cell_data[3:0], 4'h0};
            GRAY:   pix = {3{mem.cell_data[7:4]}};
            RGB332: pix = {mem.cell_data[7:5], mem.cell_data[7],
                           mem.cell_data[4:2], mem.cell_data[4],
                           mem.cell_data[1:0], mem.cell_data[1:0]};
            MONO:   pix = (mem.cell_data != '0) ? '1 : '0;
            default: pix = '0;
        endcase
        if (blink_on) pix = ~pix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {r, g, b}   <= '0;
            vga_h_sync  <= 1'b1;
            vga_v_sync  <= 1'b1;
            in_display  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            {r, g, b}   <= act_d[MEM_LAT-1] ? pix : '0;
            vga_h_sync  <= hs_d[MEM_LAT-1];
            vga_v_sync  <= vs_d[MEM_LAT-1];
            in_display  <= act_d[MEM_LAT-1];
            frame_start <= org_d[MEM_LAT-1];
        end
    end
endmodule

// File: tb/tb_vga_cell_renderer.sv
// Scoreboard bench for vga_cell_renderer on a shrunken raster with MEM_LAT=2;
// expected pixels come from a coordinate-level model of the scan.
module tb_vga_cell_renderer;
    localparam int HA = 32, HF = 4, HS = 6, HB = 6;
    localparam int VA = 24, VF = 2, VS = 2, VB = 4;
    localparam int CS = 3, CW = 7, RW = 7, LAT = 2, BS = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       fs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } px_t;

    localparam px_t IDLE_PX = '{hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0};

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       mode;
    logic [RW+CW-1:0] cursor_addr;
    logic             cursor_en;
    logic             vga_h_sync, vga_v_sync, in_display, frame_start;
    logic [3:0]       r, g, b;

    always #5 clk = ~clk;

    vga_cell_renderer_if #(.ADDR_W(RW + CW)) mem_if ();

    vga_cell_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL_SHIFT(CS), .COL_W(CW), .ROW_W(RW),
        .MEM_LAT(LAT), .BLINK_SHIFT(BS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .mem(mem_if),
        .cursor_addr(cursor_addr),
        .cursor_en(cursor_en),
        .vga_h_sync(vga_h_sync),
        .vga_v_sync(vga_v_sync),
        .r(r),
        .g(g),
        .b(b),
        .in_display(in_display),
        .frame_start(frame_start)
    );

    // Framebuffer with one register stage after the address register: two cycles of latency.
    logic [7:0] cells [0:(1 << (RW + CW)) - 1];
    always @(posedge clk) mem_if.cell_data <= cells[mem_if.cell_addr];

    px_t sb[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    int  n = 0;
    int  fmode = 0;

    function automatic px_t model(input int x, input int y, input int md,
                                  input int frame_idx, input bit cen, input int caddr);
        px_t p;
        int  d, addr;
        p     = '0;
        p.act = (x < HA) && (y < VA);
        p.hs  = !(x >= HA + HF && x < HA + HF + HS);
        p.vs  = !(y >= VA + VF && y < VA + VF + VS);
        p.fs  = (x == 0) && (y == 0);
        if (p.act) begin
            addr = (y / (1 << CS)) * (1 << CW) + x / (1 << CS);
            d    = int'(cells[addr]);
            case (md)
                0: begin p.r = 4'(d >> 4); p.g = 4'(d & 15); p.b = 4'h0; end
                1: begin p.r = 4'(d >> 4); p.g = 4'(d >> 4); p.b = 4'(d >> 4); end
                2: begin
                    p.r = 4'(((d >> 5) << 1) | (d >> 7));
                    p.g = 4'(((d >> 2) & 7) << 1 | ((d >> 4) & 1));
                    p.b = 4'(((d & 3) << 2) | (d & 3));
                end
                default: begin
                    p.r = (d != 0) ? 4'hF : 4'h0;
                    p.g = p.r;
                    p.b = p.r;
                end
            endcase
`ifdef VGA_CURSOR_EN
            // frame counter reads frame_idx+1 while frame frame_idx is on screen
            if (cen && caddr == addr && (((frame_idx + 1) >> BS) & 1) == 1) begin
                p.r = 4'hF - p.r;
                p.g = 4'hF - p.g;
                p.b = 4'hF - p.b;
            end
`endif
        end
        return p;
    endfunction

    always @(posedge clk) begin
        px_t e, got;
        #1;
        if (mon_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: DUT output with no expected entry at %0t", $time);
            end else begin
                e   = sb.pop_front();
                got = {vga_h_sync, vga_v_sync, in_display, frame_start, r, g, b};
                if (got !== e) begin
                    errors++;
                    $display("FAIL pixel at %0t: got hs=%0b vs=%0b de=%0b fs=%0b rgb=%h%h%h, expected hs=%0b vs=%0b de=%0b fs=%0b rgb=%h%h%h",
                             $time, got.hs, got.vs, got.act, got.fs, got.r, got.g, got.b,
                             e.hs, e.vs, e.act, e.fs, e.r, e.g, e.b);
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        px_t got;
        got = {vga_h_sync, vga_v_sync, in_display, frame_start, r, g, b};
        checks++;
        if (got !== IDLE_PX) begin
            errors++;
            $display("FAIL %s outputs: got %h, expected %h", tag, got, IDLE_PX);
        end
        checks++;
        if (mem_if.cell_addr !== '0) begin
            errors++;
            $display("FAIL %s cell_addr: got %h, expected 0", tag, mem_if.cell_addr);
        end
    endtask

    // Called on the falling edge right after the last reset edge (counter cycle 0).
    task automatic start_scan();
        reset = 1'b0;
        sb.delete();
        repeat (LAT) sb.push_back(IDLE_PX);
        n      = 0;
        mon_en = 1'b1;
    endtask

    task automatic run(input int cycles);
        int x, y, k, px, py, exp_addr;
        for (int i = 0; i < cycles; i++) begin
            x = n % HT;
            y = (n / HT) % VT;
            k = n / FRAME;
            exp_addr = 0;
            if (n > 0) begin
                px = (n - 1) % HT;
                py = ((n - 1) / HT) % VT;
                exp_addr = (py >> CS) * (1 << CW) + (px >> CS);
            end
            checks++;
            if (mem_if.cell_addr !== (RW + CW)'(exp_addr)) begin
                errors++;
                $display("FAIL cell_addr at cycle %0d: got %h, expected %h", n, mem_if.cell_addr, exp_addr);
            end
            if (x == 0 && y == 0) begin
                case (k)
                    0, 1: mode = 2'd0;
                    2:    mode = 2'd2;
                    3:    mode = 2'd1;
                    4:    mode = 2'd3;
                    default: mode = 2'($urandom_range(0, 3));
                endcase
                fmode = int'(mode);
                if (k < 5) begin
                    cursor_en   = 1'b1;
                    cursor_addr = '0;
                end else begin
                    cursor_en   = 1'($urandom_range(0, 1));
                    cursor_addr = (RW + CW)'($urandom_range(0, 2) * (1 << CW) + $urandom_range(0, 3));
                end
            end else if (x == 0 && y == 10) begin
                // mid-frame request: must not show until the next frame
                mode = (k == 3) ? 2'd3 : 2'($urandom_range(0, 3));
            end
            sb.push_back(model(x, y, fmode, k, cursor_en, int'(cursor_addr)));
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset       = 1'b1;
        mode        = 2'd0;
        cursor_en   = 1'b0;
        cursor_addr = '0;
        for (int i = 0; i < (1 << (RW + CW)); i++)
            cells[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        cells[0]   = 8'h5A;
        cells[1]   = 8'h00;
        cells[129] = 8'hE3;

        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset("reset_hold");
        end
        @(negedge clk);
        start_scan();
        run(8 * FRAME);

        // reset in the middle of an hsync pulse inside the vsync lines
        run((VA + VF) * HT + HA + HF + 2);
        reset  = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        check_reset("reset_mid");
        @(negedge clk);
        start_scan();
        run(4 * FRAME + 100);

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        mon_en = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected pixels never produced, expected 0 left", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
